pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_slot.sv | 25 ++
 rtl/pipe_skid_stage.sv | 124 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and bubble control constant for the skid stage
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [12:0] BUBBLE_CTRL_DEFAULT = 13'h0059;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - load-enabled payload+control register with async active-low clear
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] slot_q;

  // Capture d on load; clear to zero while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else if (load) begin
      slot_q <= d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-slot registered skid stage with flush and bubble control
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 160,
  parameter int                 CTRL_W      = 13,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = BUBBLE_CTRL_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int SLOT_W = DATA_W + CTRL_W;

  state_e            state_q;
  state_e            state_d;
  logic              main_load;
  logic              skid_load;
  logic              main_from_skid;
  logic              in_xfer;
  logic              out_xfer;
  logic [SLOT_W-1:0] main_d;
  logic [SLOT_W-1:0] main_q;
  logic [SLOT_W-1:0] skid_q;

  // in_ready depends on state only, so out_ready never reaches it combinationally.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Main is refilled either from the input or, when draining FULL, from skid.
  assign main_d = main_from_skid ? skid_q : {in_data, in_ctrl};

  // Out data always reflects main; when empty it keeps the last presented payload.
  assign out_data = main_q[SLOT_W-1:CTRL_W];
  assign out_ctrl = (state_q == ST_EMPTY) ? BUBBLE_CTRL : main_q[CTRL_W-1:0];

  pipe_slot #(.W(SLOT_W)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.W(SLOT_W)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .d     ({in_data, in_ctrl}),
    .q     (skid_q)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and slot load enables; flush drops everything and suppresses all loads
  // so the presented payload stays put while the stage reads as empty.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (out_xfer) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // Occupancy count per state.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage against a queue model
module tb_pipe_skid_stage;

  localparam int          DW     = 160;
  localparam int          CW     = 13;
  localparam logic [12:0] BUBBLE = 13'h0059;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int            pass_cnt = 0;
  int            total_cnt = 0;
  int            fail_cnt = 0;

  ent_t          mq[$];
  logic [DW-1:0] last_d;

  pipe_skid_stage dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the transaction-level model.
  task automatic check_model(input string tag);
    logic [DW-1:0] exp_d;
    logic [CW-1:0] exp_c;
    exp_d = (mq.size() > 0) ? mq[0].d : last_d;
    exp_c = (mq.size() > 0) ? mq[0].c : BUBBLE;
    check({tag, ".occupancy"}, DW'(occupancy), DW'(mq.size()));
    check({tag, ".in_ready"},  DW'(in_ready),  DW'(mq.size() < 2));
    check({tag, ".out_valid"}, DW'(out_valid), DW'(mq.size() > 0));
    check({tag, ".out_data"},  out_data,       exp_d);
    check({tag, ".out_ctrl"},  DW'(out_ctrl),  DW'(exp_c));
  endtask

  task automatic model_reset();
    mq.delete();
    last_d = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] id,
                       input logic [CW-1:0] ic, input logic ordy, input logic fl);
    bit   ix;
    bit   ox;
    ent_t e;
    in_valid  = iv;
    in_data   = id;
    in_ctrl   = ic;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_model(tag);
    ix = iv && (mq.size() < 2);
    ox = (mq.size() > 0) && ordy;
    if (mq.size() > 0) last_d = mq[0].d;
    @(posedge clock);
    #1;
    if (ox) void'(mq.pop_front());
    if (fl) begin
      mq.delete();
    end else if (ix) begin
      e.d = id;
      e.c = ic;
      mq.push_back(e);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [CW-1:0] ca;
    logic [CW-1:0] cb;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("reset.out_valid", DW'(out_valid), DW'(0));
    check("reset.in_ready",  DW'(in_ready),  DW'(1));
    check("reset.occupancy", DW'(occupancy), DW'(0));
    check("reset.out_ctrl",  DW'(out_ctrl),  DW'(BUBBLE));
    check("reset.out_data",  out_data,       DW'(0));

    // Streaming 1..8 with downstream always ready.
    for (int k = 1; k <= 8; k++) begin
      cycle("stream", 1'b1, DW'(k), CW'(k + 100), 1'b1, 1'b0);
      check("stream.out_data", out_data, DW'(k));
      check("stream.in_ready", DW'(in_ready), DW'(1));
    end
    cycle("drain", 1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure and stall stability.
    ca = 13'h0123;
    cb = 13'h0456;
    cycle("bp.a", 1'b1, DW'('hA), ca, 1'b1, 1'b0);
    cycle("bp.b", 1'b1, DW'('hB), cb, 1'b0, 1'b0);
    check("bp.occupancy", DW'(occupancy), DW'(2));
    check("bp.in_ready",  DW'(in_ready),  DW'(0));
    for (int k = 0; k < 5; k++) begin
      cycle("stall", 1'b0, '0, '0, 1'b0, 1'b0);
      check("stall.out_data", out_data, DW'('hA));
      check("stall.out_ctrl", DW'(out_ctrl), DW'(ca));
    end
    cycle("bp.popa", 1'b0, '0, '0, 1'b1, 1'b0);
    check("bp.second", out_data, DW'('hB));
    check("bp.in_ready_back", DW'(in_ready), DW'(1));
    cycle("bp.popb", 1'b0, '0, '0, 1'b1, 1'b0);
    check("bp.empty_ctrl", DW'(out_ctrl), DW'(BUBBLE));
    check("bp.empty_data", out_data, DW'('hB));

    // Flush while FULL with a new entry offered.
    cycle("fl.a", 1'b1, DW'('hA), ca, 1'b0, 1'b0);
    cycle("fl.b", 1'b1, DW'('hB), cb, 1'b0, 1'b0);
    cycle("fl.c", 1'b1, DW'('hC), 13'h0777, 1'b0, 1'b1);
    check("flush.out_valid", DW'(out_valid), DW'(0));
    check("flush.out_ctrl",  DW'(out_ctrl),  DW'(BUBBLE));
    check("flush.occupancy", DW'(occupancy), DW'(0));
    for (int k = 0; k < 3; k++) begin
      cycle("postflush", 1'b0, '0, '0, 1'b1, 1'b0);
      check("postflush.out_valid", DW'(out_valid), DW'(0));
    end

    // Asynchronous reset while FULL.
    cycle("rst.a", 1'b1, rand_data(), CW'($urandom), 1'b0, 1'b0);
    cycle("rst.b", 1'b1, rand_data(), CW'($urandom), 1'b0, 1'b0);
    check("rst.full", DW'(occupancy), DW'(2));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("midrst.out_valid", DW'(out_valid), DW'(0));
    check("midrst.in_ready",  DW'(in_ready),  DW'(1));
    check("midrst.occupancy", DW'(occupancy), DW'(0));
    check("midrst.out_ctrl",  DW'(out_ctrl),  DW'(BUBBLE));
    check("midrst.out_data",  out_data,       DW'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    cycle("postrst", 1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      cycle("rand", ($urandom_range(3, 0) != 0), rand_data(), CW'($urandom),
            ($urandom_range(2, 0) != 0), ($urandom_range(19, 0) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
